muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide sequencer that sits beside the single-cycle ALU in the execute stage. It accepts one operation per handshake, runs a fixed 32-step shift-add multiply or restoring divide, and returns a 32-bit result. It also stalls the pipeline for the duration of the operation. The unit is selected when the decoder sees OP with Funct7 = 0000001; Funct3 picks the operation.

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply or
// restoring divide on operand magnitudes, sign-corrected into Result on DONE.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic [XLEN-1:0] Result,
   output logic            busy,
   output logic            done,
   output logic            stall
);
   localparam int PW = 2*XLEN + 1;
   localparam logic [5:0] LAST = 6'(XLEN - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   amag_q, amag_d, bmag_q, bmag_d;
   logic              aneg_q, aneg_d, bneg_q, bneg_d;
   logic [PW-1:0]     p_q, p_d;
   logic [XLEN-1:0]   res_q, res_d;

   // Operand decode on the request side: unsigned ops never see a sign flag.
   logic            a_sgn, b_sgn, a_neg_in, b_neg_in;
   logic [XLEN-1:0] a_mag_in, b_mag_in;
   always_comb begin
      a_sgn    = !(Funct3 inside {3'b011, 3'b101, 3'b111});
      b_sgn    = a_sgn && (Funct3 != 3'b010);
      a_neg_in = a_sgn && SrcA[XLEN-1];
      b_neg_in = b_sgn && SrcB[XLEN-1];
      a_mag_in = a_neg_in ? -SrcA : SrcA;
      b_mag_in = b_neg_in ? -SrcB : SrcB;
   end

   // p_q holds {acc_hi, multiplier} for multiply, {remainder, dividend/quotient} for divide.
   logic [XLEN:0]   mul_sum, div_sh;
   logic [XLEN+1:0] div_diff;
   logic            div_ok;
   logic [PW-1:0]   mul_nxt, div_nxt, step;
   always_comb begin
      mul_sum  = p_q[PW-1:XLEN] + (p_q[0] ? {1'b0, amag_q} : '0);
      mul_nxt  = {1'b0, mul_sum, p_q[XLEN-1:1]};
      div_sh   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
      div_diff = {1'b0, div_sh} - {2'b0, bmag_q};
      div_ok   = ~div_diff[XLEN+1];
      div_nxt  = {(div_ok ? div_diff[XLEN:0] : div_sh), p_q[XLEN-2:0], div_ok};
      step     = f3_q[2] ? div_nxt : mul_nxt;
   end

   // Divide-by-zero naturally yields quotient all-ones and remainder = |SrcA|;
   // only the quotient needs its sign correction suppressed.
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo, rem, quo_s, rem_s, fin;
   logic              div0;
   always_comb begin
      prod   = step[2*XLEN-1:0];
      prod_s = (aneg_q ^ bneg_q) ? -prod : prod;
      quo    = step[XLEN-1:0];
      rem    = step[2*XLEN-1:XLEN];
      div0   = (bmag_q == '0);
      quo_s  = div0 ? '1 : ((aneg_q ^ bneg_q) ? -quo : quo);
      rem_s  = aneg_q ? -rem : rem;
      fin    = '0;
      case (f3_q)
         3'b000:                 fin = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fin = quo_s;
         default:                fin = rem_s;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      amag_d  = amag_q;
      bmag_d  = bmag_q;
      aneg_d  = aneg_q;
      bneg_d  = bneg_q;
      p_d     = p_q;
      res_d   = res_q;
      case (state_q)
         IDLE: if (start && !flush) begin
            state_d = RUN;
            cnt_d   = '0;
            f3_d    = Funct3;
            amag_d  = a_mag_in;
            bmag_d  = b_mag_in;
            aneg_d  = a_neg_in;
            bneg_d  = b_neg_in;
            p_d     = {{(XLEN+1){1'b0}}, (Funct3[2] ? a_mag_in : b_mag_in)};
         end
         RUN: if (flush) begin
            state_d = IDLE;
         end else begin
            p_d   = step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LAST) begin
               state_d = DONE;
               res_d   = fin;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         amag_q  <= '0;
         bmag_q  <= '0;
         aneg_q  <= 1'b0;
         bneg_q  <= 1'b0;
         p_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         amag_q  <= amag_d;
         bmag_q  <= bmag_d;
         aneg_q  <= aneg_d;
         bneg_q  <= bneg_d;
         p_q     <= p_d;
         res_q   <= res_d;
      end
   end

   assign Result = res_q;
   assign busy   = (state_q == RUN) || (state_q == DONE);
   assign done   = (state_q == DONE);
   assign stall  = (state_q == RUN) || ((state_q == IDLE) && start && !flush);
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected result and done
// cycle, an independent monitor pops and compares on every done pulse.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  Funct3;
   logic [31:0] SrcA, SrcB, Result;
   logic        busy, done, stall;

   int checks = 0, errors = 0, cyc = 0, busy_cnt = 0, done_cnt = 0;

   typedef struct { logic [31:0] val; int cyc; } exp_t;
   exp_t sb[$];

   typedef struct { logic [2:0] f; logic [31:0] a, b, r; } vec_t;
   vec_t vecs [19] = '{
      '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
      '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
      '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
      '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
      '{3'd5, 32'd100,      32'd7,        32'd14},
      '{3'd7, 32'd100,      32'd7,        32'd2},
      '{3'd5, 32'h12345678, 32'd0,        32'hFFFFFFFF},
      '{3'd7, 32'h12345678, 32'd0,        32'h12345678},
      '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
      '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
      '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1},
      '{3'd0, 32'h12345678, 32'h10,       32'h23456780},
      '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000},
      '{3'd3, 32'h80000000, 32'd4,        32'h00000002},
      '{3'd4, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2},
      '{3'd6, 32'd100,      32'hFFFFFFF9, 32'd2},
      '{3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF},
      '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9}
   };

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .flush(flush), .Funct3(Funct3),
      .SrcA(SrcA), .SrcB(SrcB), .Result(Result), .busy(busy), .done(done), .stall(stall)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk); #1;
   endtask

   // Accept happens at the next rising edge; done is expected 32 edges later.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input bit push);
      start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
      #1 chk("stall_accept", 32'(stall), 32'd1);
      if (push) sb.push_back('{r, cyc + 33});
      tick;
      start = 1'b0; Funct3 = ~f; SrcA = ~a; SrcB = ~b;
   endtask

   task automatic wait_done;
      for (int i = 0; i < 50 && sb.size() != 0; i++) tick;
      if (sb.size() != 0) begin
         chk("done_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      tick;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) chk("unexpected_done", 32'(sb.size()), 32'd1);
            else begin
               e = sb.pop_front();
               chk("result", Result, e.val);
               chk("latency", 32'(cyc), 32'(e.cyc));
               chk("stall_in_done", 32'(stall), 32'd0);
            end
         end
      end
   end

   initial begin
      int b0, d0;
      reset = 1'b1; start = 1'b0; flush = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
      tick; tick;
      chk("rst_result", Result, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      reset = 1'b0;
      tick;

      b0 = busy_cnt;
      issue(3'd0, 32'd7, 32'd6, 32'h2A, 1'b1);
      wait_done;
      chk("busy_cycles", 32'(busy_cnt - b0), 32'd33);

      foreach (vecs[i]) begin
         issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, 1'b1);
         wait_done;
      end

      // Extra start pulses in RUN and DONE must be ignored.
      d0 = done_cnt;
      issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
      tick; tick; tick;
      start = 1'b1; Funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd5;
      #1 chk("stall_run", 32'(stall), 32'd1);
      tick;
      start = 1'b0;
      for (int i = 0; i < 40 && done !== 1'b1; i++) tick;
      chk("done_seen", 32'(done), 32'd1);
      start = 1'b1; Funct3 = 3'd7;
      tick;
      start = 1'b0;
      repeat (40) tick;
      chk("one_done", 32'(done_cnt - d0), 32'd1);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      // Flush mid-RUN.
      d0 = done_cnt;
      issue(3'd0, 32'd3, 32'd3, 32'd9, 1'b0);
      repeat (9) tick;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_result", Result, 32'd14);
      repeat (40) tick;
      chk("flush_result_hold", Result, 32'd14);
      chk("flush_no_done", 32'(done_cnt - d0), 32'd0);

      // start together with flush in IDLE is not accepted.
      start = 1'b1; flush = 1'b1;
      #1 chk("startflush_stall", 32'(stall), 32'd0);
      tick;
      start = 1'b0; flush = 1'b0;
      chk("startflush_busy", 32'(busy), 32'd0);

      // Asynchronous reset mid-RUN.
      d0 = done_cnt;
      issue(3'd0, 32'd7, 32'd6, 32'h2A, 1'b0);
      repeat (5) tick;
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_result", Result, 32'd0);
      tick;
      reset = 1'b0;
      repeat (40) tick;
      chk("arst_no_done", 32'(done_cnt - d0), 32'd0);

      issue(3'd0, 32'd7, 32'd6, 32'h2A, 1'b1);
      wait_done;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
